// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: shared LED width and scheduler state encoding for the LED blocks
package led_sequencer_pkg;
  localparam int LED_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2, MTNE = 2'd3} state_t;
endpackage

// File: rtl/led_req_arbiter.sv
// led_req_arbiter: combinational requester pick; LED_SEQ_ROUND_ROBIN_EN selects round-robin
// from rr_ptr, otherwise fixed priority with the lowest index winning.
module led_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifdef LED_SEQ_ROUND_ROBIN_EN
  input  logic [IW-1:0]    rr_ptr,
`endif
  output logic [IW-1:0]    winner,
  output logic             any_req
);
  assign any_req = |req;
`ifdef LED_SEQ_ROUND_ROBIN_EN
  int idx;
  // Scan backwards so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    winner = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req[idx]) winner = IW'(idx);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) winner = IW'(i);
  end
`endif
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: grants one requester's LED pattern at a time, holds it, then blanks for a gap.
// LED_SEQ_ROUND_ROBIN_EN enables round-robin arbitration (default: fixed priority).
module led_sequencer import led_sequencer_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int TICK_DIV = 5000000,
  parameter int HOLD_TICKS = 10,
  parameter int GAP_TICKS = 1,
  parameter logic [LED_W-1:0] IDLE_PATTERN = 6'b000100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [LED_W*N_REQ-1:0]     req_pattern,
  input  logic                       mtne_req,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [LED_W-1:0]           led_enable,
  output logic                       mtne_mode
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  localparam int GW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
  state_t state, state_d;
  logic [TW-1:0] tick_cnt, tick_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [N_REQ-1:0] ack_d;
  logic [IW-1:0] grant_d, winner;
  logic [LED_W-1:0] led_d, win_pat;
  logic busy_d, mtne_d, any_req, start, tick, hold_end, gap_end;
`ifdef LED_SEQ_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;
  led_req_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (.req, .rr_ptr, .winner, .any_req);
  always_ff @(posedge clock or negedge reset)
    if (!reset) rr_ptr <= '0;
    else if (start) rr_ptr <= int'(winner) == N_REQ - 1 ? '0 : winner + 1'b1;
`else
  led_req_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (.req, .winner, .any_req);
`endif
  assign win_pat = req_pattern[int'(winner)*LED_W +: LED_W];
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign hold_end = tick && hold_cnt == HW'(HOLD_TICKS - 1);
  assign gap_end = tick && gap_cnt == GW'(GAP_TICKS - 1);
  always_comb begin
    state_d = state;
    tick_d = (state == HOLD || state == GAP) && !tick ? tick_cnt + 1'b1 : '0;
    hold_d = state == HOLD && tick && !hold_end ? hold_cnt + 1'b1 : hold_cnt;
    gap_d = state == GAP && tick && !gap_end ? gap_cnt + 1'b1 : gap_cnt;
    ack_d = '0;
    grant_d = grant_id;
    led_d = led_enable;
    mtne_d = 1'b0;
    start = 1'b0;
    if (mtne_req) begin
      state_d = MTNE;
      led_d = '0;
      mtne_d = 1'b1;
    end else case (state)
      IDLE: start = any_req;
      HOLD: if (!req[grant_id] || hold_end) begin
        state_d = GAP;
        led_d = '0;
        tick_d = '0;
        gap_d = '0;
        ack_d[grant_id] = req[grant_id];
      end
      GAP: if (gap_end) begin
        state_d = IDLE;
        led_d = IDLE_PATTERN;
        start = any_req;
      end
      default: begin
        state_d = IDLE;
        led_d = IDLE_PATTERN;
      end
    endcase
    if (start) begin
      state_d = HOLD;
      grant_d = winner;
      led_d = win_pat;
      tick_d = '0;
      hold_d = '0;
    end
    busy_d = state_d == HOLD || state_d == GAP;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      hold_cnt <= '0;
      gap_cnt <= '0;
      ack <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      led_enable <= IDLE_PATTERN;
      mtne_mode <= 1'b0;
    end else begin
      state <= state_d;
      tick_cnt <= tick_d;
      hold_cnt <= hold_d;
      gap_cnt <= gap_d;
      ack <= ack_d;
      grant_id <= grant_d;
      busy <= busy_d;
      led_enable <= led_d;
      mtne_mode <= mtne_d;
    end
endmodule
